// File: rtl/traffic_pkg.sv
// Shared phase encoding and light-head constants for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_NS_GREEN,
        PH_NS_YELLOW,
        PH_ALL_RED_A,
        PH_EW_GREEN,
        PH_EW_YELLOW,
        PH_ALL_RED_B,
        PH_PED_WALK,
        PH_PED_CLEAR
    } phase_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that saturates at zero; done flags an expired phase.
module phase_timer #(
    parameter int           W       = 5,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-driven phase scheduler for an NS/EW intersection with a ped crossing.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int NS_MIN_GREEN = 20,
    parameter int EW_GREEN     = 12,
    parameter int YELLOW       = 4,
    parameter int ALL_RED      = 2,
    parameter int PED_WALK     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       walk,
    output logic       ped_wait,
    output logic       ped_ack
);

    localparam int MAXD = imax(imax(imax(NS_MIN_GREEN, EW_GREEN),
                                    imax(YELLOW, ALL_RED)), PED_WALK);
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    phase_e        state;
    phase_e        state_n;
    logic          ew_pending;
    logic          ped_pending;
    logic          ew_pending_n;
    logic          ped_pending_n;
    logic          entering;
    logic          done;
    logic [TW-1:0] count;
    logic [TW-1:0] load_val;

    function automatic logic [TW-1:0] dur(input phase_e p);
        logic [TW-1:0] d;
        unique case (p)
            PH_NS_GREEN:  d = TW'(NS_MIN_GREEN - 1);
            PH_NS_YELLOW: d = TW'(YELLOW - 1);
            PH_ALL_RED_A: d = TW'(ALL_RED - 1);
            PH_EW_GREEN:  d = TW'(EW_GREEN - 1);
            PH_EW_YELLOW: d = TW'(YELLOW - 1);
            PH_ALL_RED_B: d = TW'(ALL_RED - 1);
            PH_PED_WALK:  d = TW'(PED_WALK - 1);
            PH_PED_CLEAR: d = TW'(ALL_RED - 1);
            default:      d = '0;
        endcase
        return d;
    endfunction

    phase_timer #(
        .W       (TW),
        .RST_VAL (TW'(NS_MIN_GREEN - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (entering),
        .load_val (load_val),
        .count    (count),
        .done     (done)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            PH_NS_GREEN:
                if (done && (ew_pending || ped_pending))
                    state_n = PH_NS_YELLOW;
            PH_NS_YELLOW:
                if (done) state_n = PH_ALL_RED_A;
            PH_ALL_RED_A:
                if (done)
                    state_n = ew_pending ? PH_EW_GREEN : PH_PED_WALK;
            PH_EW_GREEN:
                if (done) state_n = PH_EW_YELLOW;
            PH_EW_YELLOW:
                if (done) state_n = PH_ALL_RED_B;
            PH_ALL_RED_B:
                if (done)
                    state_n = ped_pending ? PH_PED_WALK : PH_NS_GREEN;
            PH_PED_WALK:
                if (done) state_n = PH_PED_CLEAR;
            PH_PED_CLEAR:
                if (done) state_n = PH_NS_GREEN;
            default:
                state_n = PH_NS_GREEN;
        endcase
    end

    assign entering = (state_n != state);
    assign load_val = dur(state_n);

    // Requests during the phase that serves them are absorbed; clear beats set.
    always_comb begin
        ew_pending_n  = ew_pending  | (ew_car  & (state != PH_EW_GREEN));
        ped_pending_n = ped_pending | (ped_req & (state != PH_PED_WALK));
        if (entering && state_n == PH_EW_GREEN) ew_pending_n = 1'b0;
        if (entering && state_n == PH_PED_WALK) ped_pending_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= PH_NS_GREEN;
            ew_pending  <= 1'b0;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_n;
            ew_pending  <= ew_pending_n;
            ped_pending <= ped_pending_n;
            ped_ack     <= entering && (state_n == PH_PED_WALK);
        end
    end

    always_comb begin
        ns_lights = LIGHT_RED;
        ew_lights = LIGHT_RED;
        walk      = 1'b0;
        unique case (1'b1)
            (state == PH_NS_GREEN):  ns_lights = LIGHT_GREEN;
            (state == PH_NS_YELLOW): ns_lights = LIGHT_YELLOW;
            (state == PH_EW_GREEN):  ew_lights = LIGHT_GREEN;
            (state == PH_EW_YELLOW): ew_lights = LIGHT_YELLOW;
            (state == PH_PED_WALK):  walk      = 1'b1;
            default: ;
        endcase
    end

    assign ped_wait = ped_pending;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: phase lengths, demand latching,
// ped_ack pulse, async reset and the one-active-movement safety rule.
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       walk;
    logic       ped_wait;
    logic       ped_ack;

    int passes = 0;
    int fails  = 0;
    int acks   = 0;

    localparam logic [6:0] P_NSG  = {3'b001, 3'b100, 1'b0};
    localparam logic [6:0] P_NSY  = {3'b010, 3'b100, 1'b0};
    localparam logic [6:0] P_RED  = {3'b100, 3'b100, 1'b0};
    localparam logic [6:0] P_EWG  = {3'b100, 3'b001, 1'b0};
    localparam logic [6:0] P_EWY  = {3'b100, 3'b010, 1'b0};
    localparam logic [6:0] P_WALK = {3'b100, 3'b100, 1'b1};

    intersection_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .ew_car    (ew_car),
        .ped_req   (ped_req),
        .ns_lights (ns_lights),
        .ew_lights (ew_lights),
        .walk      (walk),
        .ped_wait  (ped_wait),
        .ped_ack   (ped_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!reset && ped_ack) acks++;

    always @(negedge clk) begin
        if (!reset) begin
            int act;
            act = int'(ns_lights != 3'b100) + int'(ew_lights != 3'b100)
                + int'(walk);
            if (act > 1) begin
                fails++;
                $display("FAIL safety ns=%b ew=%b walk=%b want at most one active",
                         ns_lights, ew_lights, walk);
            end else passes++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        ew_car = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_len(input logic [6:0] pat, output int n);
        n = 0;
        while ({ns_lights, ew_lights, walk} === pat && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        if (ns_lights !== 3'b001) begin
            fails++; $display("FAIL reset_ns got %b want 001", ns_lights);
        end else passes++;
        if (ew_lights !== 3'b100) begin
            fails++; $display("FAIL reset_ew got %b want 100", ew_lights);
        end else passes++;
        if (walk !== 1'b0) begin
            fails++; $display("FAIL reset_walk got %b want 0", walk);
        end else passes++;
        if (ped_wait !== 1'b0 || ped_ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_ped got wait=%b ack=%b want 0 0", ped_wait, ped_ack);
        end else passes++;
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        if ({ns_lights, ew_lights, walk} !== P_NSG) begin
            fails++;
            $display("FAIL idle_rest got %b want %b", {ns_lights, ew_lights, walk}, P_NSG);
        end else passes++;
    endtask

    task automatic test_ew_service();
        int n;
        int a0;
        do_reset();
        repeat (40) @(negedge clk);
        a0 = acks;
        ew_car = 1'b1;
        @(negedge clk);
        ew_car = 1'b0;
        run_len(P_NSG, n);
        if (n !== 1) begin
            fails++; $display("FAIL ew_green_tail got %0d want 1", n);
        end else passes++;
        run_len(P_NSY, n);
        if (n !== 4) begin
            fails++; $display("FAIL ew_ns_yellow got %0d want 4", n);
        end else passes++;
        run_len(P_RED, n);
        if (n !== 2) begin
            fails++; $display("FAIL ew_allred_a got %0d want 2", n);
        end else passes++;
        run_len(P_EWG, n);
        if (n !== 12) begin
            fails++; $display("FAIL ew_green got %0d want 12", n);
        end else passes++;
        run_len(P_EWY, n);
        if (n !== 4) begin
            fails++; $display("FAIL ew_yellow got %0d want 4", n);
        end else passes++;
        run_len(P_RED, n);
        if (n !== 2) begin
            fails++; $display("FAIL ew_allred_b got %0d want 2", n);
        end else passes++;
        if ({ns_lights, ew_lights, walk} !== P_NSG) begin
            fails++;
            $display("FAIL ew_return got %b want %b", {ns_lights, ew_lights, walk}, P_NSG);
        end else passes++;
        if (acks !== a0 || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL ew_no_ped got acks=%0d wait=%b want %0d 0", acks, ped_wait, a0);
        end else passes++;
    endtask

    task automatic test_ped_service();
        int n;
        do_reset();
        repeat (5) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        if (ped_wait !== 1'b1) begin
            fails++; $display("FAIL ped_wait_set got %b want 1", ped_wait);
        end else passes++;
        run_len(P_NSG, n);
        if (n !== 14) begin
            fails++; $display("FAIL ped_min_green got %0d want 14", n);
        end else passes++;
        run_len(P_NSY, n);
        if (n !== 4) begin
            fails++; $display("FAIL ped_ns_yellow got %0d want 4", n);
        end else passes++;
        run_len(P_RED, n);
        if (n !== 2) begin
            fails++; $display("FAIL ped_allred_a got %0d want 2", n);
        end else passes++;
        if (walk !== 1'b1 || ped_ack !== 1'b1 || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL ped_entry got walk=%b ack=%b wait=%b want 1 1 0",
                     walk, ped_ack, ped_wait);
        end else passes++;
        @(negedge clk);
        if (ped_ack !== 1'b0) begin
            fails++; $display("FAIL ped_ack_width got %b want 0", ped_ack);
        end else passes++;
        run_len(P_WALK, n);
        if (n !== 7) begin
            fails++; $display("FAIL ped_walk_rest got %0d want 7", n);
        end else passes++;
        run_len(P_RED, n);
        if (n !== 2) begin
            fails++; $display("FAIL ped_clear got %0d want 2", n);
        end else passes++;
        if ({ns_lights, ew_lights, walk} !== P_NSG || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL ped_return got %b wait=%b want %b 0",
                     {ns_lights, ew_lights, walk}, ped_wait, P_NSG);
        end else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        repeat (3) @(negedge clk);
        ew_car = 1'b1;
        ped_req = 1'b1;
        @(negedge clk);
        ew_car = 1'b0;
        ped_req = 1'b0;
        run_len(P_NSG, n);
        if (n !== 16) begin
            fails++; $display("FAIL both_green got %0d want 16", n);
        end else passes++;
        run_len(P_NSY, n);
        run_len(P_RED, n);
        if (ew_lights !== 3'b001 || ped_wait !== 1'b1) begin
            fails++;
            $display("FAIL both_ew_first got ew=%b wait=%b want 001 1", ew_lights, ped_wait);
        end else passes++;
        run_len(P_EWG, n);
        if (n !== 12) begin
            fails++; $display("FAIL both_ew_green got %0d want 12", n);
        end else passes++;
        run_len(P_EWY, n);
        run_len(P_RED, n);
        if (n !== 2) begin
            fails++; $display("FAIL both_allred_b got %0d want 2", n);
        end else passes++;
        if (walk !== 1'b1 || ped_ack !== 1'b1) begin
            fails++;
            $display("FAIL both_walk_direct got walk=%b ack=%b want 1 1", walk, ped_ack);
        end else passes++;
        run_len(P_WALK, n);
        if (n !== 8) begin
            fails++; $display("FAIL both_walk got %0d want 8", n);
        end else passes++;
        run_len(P_RED, n);
        if ({ns_lights, ew_lights, walk} !== P_NSG || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL both_return got %b wait=%b want %b 0",
                     {ns_lights, ew_lights, walk}, ped_wait, P_NSG);
        end else passes++;
    endtask

    task automatic test_ped_held();
        int n;
        int a0;
        do_reset();
        ped_req = 1'b1;
        @(negedge clk);
        run_len(P_NSG, n);
        if (n !== 19) begin
            fails++; $display("FAIL held_green got %0d want 19", n);
        end else passes++;
        run_len(P_NSY, n);
        run_len(P_RED, n);
        a0 = acks;
        if (ped_ack !== 1'b1 || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL held_entry got ack=%b wait=%b want 1 0", ped_ack, ped_wait);
        end else passes++;
        run_len(P_WALK, n);
        if (n !== 8) begin
            fails++; $display("FAIL held_walk got %0d want 8", n);
        end else passes++;
        if ({ns_lights, ew_lights, walk} !== P_RED || ped_wait !== 1'b0) begin
            fails++;
            $display("FAIL held_exit got %b wait=%b want %b 0",
                     {ns_lights, ew_lights, walk}, ped_wait, P_RED);
        end else passes++;
        ped_req = 1'b0;
        @(negedge clk);
        if (acks - a0 !== 1) begin
            fails++; $display("FAIL held_ack_pulses got %0d want 1", acks - a0);
        end else passes++;
        if (ped_wait !== 1'b0) begin
            fails++; $display("FAIL held_no_relatch got %b want 0", ped_wait);
        end else passes++;
    endtask

    task automatic test_reset_mid_ew();
        int n;
        do_reset();
        ew_car = 1'b1;
        @(negedge clk);
        ew_car = 1'b0;
        run_len(P_NSG, n);
        run_len(P_NSY, n);
        run_len(P_RED, n);
        repeat (5) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        if (ew_lights !== 3'b001 || ped_wait !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup got ew=%b wait=%b want 001 1", ew_lights, ped_wait);
        end else passes++;
        #2 reset = 1'b1;
        #1;
        if ({ns_lights, ew_lights, walk} !== P_NSG) begin
            fails++;
            $display("FAIL mid_async got %b want %b", {ns_lights, ew_lights, walk}, P_NSG);
        end else passes++;
        if (ped_wait !== 1'b0 || ped_ack !== 1'b0) begin
            fails++;
            $display("FAIL mid_pending got wait=%b ack=%b want 0 0", ped_wait, ped_ack);
        end else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        if ({ns_lights, ew_lights, walk} !== P_NSG) begin
            fails++;
            $display("FAIL mid_rest got %b want %b", {ns_lights, ew_lights, walk}, P_NSG);
        end else passes++;
    endtask

    initial begin
        test_reset();
        test_ew_service();
        test_ped_service();
        test_back_to_back();
        test_ped_held();
        test_reset_mid_ew();
        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule
